// File: rtl/gated_integrator_pkg.sv
// gated_integrator_pkg: shared FSM encoding and sign-extension helper for the windowed integrator
package gated_integrator_pkg;
  typedef enum logic [1:0] {S_FLUSH = 2'd0, S_FILL = 2'd1, S_RUN = 2'd2} state_e;
  function automatic logic [63:0] sext(input logic [63:0] v, input int unsigned w);
    return 64'($signed(v << (64 - w)) >>> (64 - w));
  endfunction
endpackage

// File: rtl/ram_dual.sv
// ram_dual: simple dual-port RAM, one write port and one registered read port (read-old on collision)
module ram_dual #(
  parameter int P_DW = 16,
  parameter int P_AW = 10
) (
  input  logic            clk,
  input  logic            we_i,
  input  logic [P_AW-1:0] waddr_i,
  input  logic [P_DW-1:0] wdata_i,
  input  logic [P_AW-1:0] raddr_i,
  output logic [P_DW-1:0] q_o
);
  logic [P_DW-1:0] mem_q [1<<P_AW];
  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
    q_o <= mem_q[raddr_i];
  end
endmodule

// File: rtl/gated_integrator_win.sv
// gated_integrator_win: moving-window boxcar integrator with runtime length, RAM flush and fill tracking
module gated_integrator_win
  import gated_integrator_pkg::*;
#(
  parameter int P_NBITS_DATA_IN  = 16,
  parameter int P_NBITS_DATA_OUT = 26,
  parameter int P_NBITS_ADDR     = 10
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        wr,
  input  logic [P_NBITS_DATA_IN-1:0]  a,
  input  logic                        len_wr,
  input  logic [P_NBITS_ADDR-1:0]     len_m1,
  input  logic                        init_wr,
  input  logic [P_NBITS_DATA_OUT-1:0] init_y,
  output logic [P_NBITS_DATA_OUT-1:0] y,
  output logic                        y_valid,
  output logic                        busy
);
  localparam int DI = P_NBITS_DATA_IN;
  localparam int DO = P_NBITS_DATA_OUT;
  localparam int AW = P_NBITS_ADDR;
  state_e state_q, state_d;
  logic [AW-1:0] len_q, ptr_q, ptr_d, cnt_q, cnt_d;
  logic [DO-1:0] y_q, y_d, a_ext, old_ext;
  logic [DI-1:0] wdata, q, fwd_dat_q, a_old;
  logic valid_q, valid_d, fwd_q, flush, acc, we, fill_done;
  always_comb begin
    flush     = state_q == S_FLUSH;
    acc       = !flush && wr && !len_wr;
    we        = flush || acc;
    wdata     = flush ? '0 : a;
    fill_done = state_q == S_FILL && acc && cnt_q == len_q;
    a_old     = fwd_q ? fwd_dat_q : q;
    a_ext     = DO'(sext(64'(a), DI));
    old_ext   = state_q == S_RUN ? DO'(sext(64'(a_old), DI)) : '0;
    ptr_d     = len_wr ? '0 : !we ? ptr_q : (!flush && ptr_q == len_q) ? '0 : ptr_q + AW'(1);
    cnt_d     = (len_wr || flush) ? '0 : (acc && state_q == S_FILL) ? cnt_q + AW'(1) : cnt_q;
    y_d       = len_wr ? '0 : (init_wr && !flush) ? init_y : acc ? y_q + a_ext - old_ext : y_q;
    valid_d   = !len_wr && (valid_q || fill_done);
    state_d   = len_wr ? S_FLUSH : (flush && &ptr_q) ? S_FILL : fill_done ? S_RUN : state_q;
  end
  // With L=1 the read and write hit the same address on one edge; forward the written sample.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_FLUSH;
      len_q     <= '0;
      ptr_q     <= '0;
      cnt_q     <= '0;
      y_q       <= '0;
      valid_q   <= 1'b0;
      fwd_q     <= 1'b0;
      fwd_dat_q <= '0;
    end else begin
      state_q   <= state_d;
      len_q     <= len_wr ? len_m1 : len_q;
      ptr_q     <= ptr_d;
      cnt_q     <= cnt_d;
      y_q       <= y_d;
      valid_q   <= valid_d;
      fwd_q     <= we && ptr_d == ptr_q;
      fwd_dat_q <= wdata;
    end
  end
  ram_dual #(.P_DW(DI), .P_AW(AW)) u_ram (
    .clk    (clk),
    .we_i   (we),
    .waddr_i(ptr_q),
    .wdata_i(wdata),
    .raddr_i(ptr_d),
    .q_o    (q)
  );
  assign y       = y_q;
  assign y_valid = valid_q;
  assign busy    = flush;
endmodule

// File: tb/tb_gated_integrator_win.sv
// tb_gated_integrator_win: vector table, corner sequences and random traffic against a window-sum model
module tb_gated_integrator_win;
  localparam int DI = 16, DO = 26, AW = 10, DEPTH = 1 << AW;
  logic clk = 1'b0, rst, wr, len_wr, init_wr, y_valid, busy;
  logic [DI-1:0] a;
  logic [AW-1:0] len_m1;
  logic [DO-1:0] init_y, y;
  always #5 clk = ~clk;
  gated_integrator_win #(.P_NBITS_DATA_IN(DI), .P_NBITS_DATA_OUT(DO), .P_NBITS_ADDR(AW)) dut (
    .clk(clk), .rst(rst), .wr(wr), .a(a), .len_wr(len_wr), .len_m1(len_m1),
    .init_wr(init_wr), .init_y(init_y), .y(y), .y_valid(y_valid), .busy(busy)
  );
  int n_chk = 0, n_pass = 0;
  int m_len = 1, m_flush = 0;
  longint m_win[$];
  longint m_y = 0;
  bit m_valid = 0;
  typedef struct {bit w; int av; bit iw; int iy; int ey; bit ev;} vec_t;
  vec_t tbl[9];
  function automatic longint sx(input logic [DO-1:0] v);
    return longint'($signed(v));
  endfunction
  task automatic chk(input string nm, input longint act, input longint exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
  endtask
  task automatic cyc(input bit r, input bit w, input int av, input bit lw, input int lm,
                     input bit iw, input longint iy);
    logic signed [DI-1:0] s;
    longint d;
    rst = r; wr = w; a = DI'(av); len_wr = lw; len_m1 = AW'(lm); init_wr = iw; init_y = DO'(iy);
    s = DI'(av);
    d = 0;
    @(posedge clk);
    if (r || lw) begin
      m_len = r ? 1 : lm + 1; m_y = 0; m_valid = 0; m_flush = DEPTH; m_win.delete();
    end else if (m_flush > 0) m_flush--;
    else begin
      if (w) begin
        m_win.push_back(longint'(s));
        d = longint'(s);
        if (m_win.size() > m_len) d -= m_win.pop_front();
        if (m_win.size() >= m_len) m_valid = 1;
      end
      m_y = iw ? iy : m_y + d;
    end
    #1;
    chk("y", sx(y), sx(DO'(m_y)));
    chk("y_valid", longint'(y_valid), longint'(m_valid));
    chk("busy", longint'(busy), longint'(m_flush > 0));
  endtask
  task automatic idle();
    cyc(0, 0, 0, 0, 0, 0, 0);
  endtask
  task automatic smp(input int av);
    cyc(0, 1, av, 0, 0, 0, 0);
  endtask
  task automatic setlen(input int lm);
    cyc(0, 0, 0, 1, lm, 0, 0);
    repeat (DEPTH) cyc(0, 1'($urandom), int'($urandom), 0, 0, 0, 0);
  endtask
  initial begin
    int bc;
    int ls[6];
    int gap_y[5];
    tbl = '{'{1, 1, 0, 0, 1, 0}, '{1, 2, 0, 0, 3, 0}, '{1, 3, 0, 0, 6, 0}, '{1, 4, 0, 0, 10, 1},
            '{1, 5, 0, 0, 14, 1}, '{1, 6, 0, 0, 18, 1}, '{1, 7, 1, 100, 100, 1},
            '{1, 0, 0, 0, 96, 1}, '{0, 0, 0, 0, 96, 1}};
    gap_y = '{-32768, -65536, -98304, -98304, -98304};
    ls = '{1, 2, 3, 5, 17, DEPTH};
    cyc(1, 0, 0, 0, 0, 0, 0);
    bc = int'(busy);
    repeat (DEPTH + 1) begin idle(); bc += int'(busy); end
    chk("busy_len", bc, DEPTH);
    chk("reset_y", sx(y), 0);
    setlen(3);
    foreach (tbl[i]) begin
      cyc(0, tbl[i].w, tbl[i].av, 0, 0, tbl[i].iw, tbl[i].iy);
      chk("tbl_y", sx(y), tbl[i].ey);
      chk("tbl_valid", longint'(y_valid), longint'(tbl[i].ev));
    end
    setlen(2);
    for (int i = 0; i < 5; i++) begin
      smp(-32768);
      chk("neg_y", sx(y), gap_y[i]);
      repeat (i) begin idle(); chk("neg_hold", sx(y), gap_y[i]); end
    end
    cyc(0, 1, 5, 1, 0, 0, 0);
    chk("len_y0", sx(y), 0);
    chk("len_busy", longint'(busy), 1);
    repeat (DEPTH) smp(int'($urandom));
    smp(9);
    chk("l1_y", sx(y), 9);
    chk("l1_valid", longint'(y_valid), 1);
    smp(-2);
    chk("l1_y2", sx(y), -2);
    setlen(1);
    repeat (3) idle();
    cyc(0, 1, 3, 1, 1, 0, 0);
    repeat (500) smp(int'($urandom));
    setlen(1);
    smp(4);
    smp(7);
    chk("restart_y", sx(y), 11);
    setlen(7);
    repeat (10) smp(int'($urandom));
    cyc(1, 1, 3, 0, 0, 0, 0);
    chk("rst_y", sx(y), 0);
    chk("rst_valid", longint'(y_valid), 0);
    chk("rst_busy", longint'(busy), 1);
    repeat (DEPTH) idle();
    smp(5);
    chk("rst_l1_a", sx(y), 5);
    smp(6);
    chk("rst_l1_b", sx(y), 6);
    foreach (ls[k]) begin
      setlen(ls[k] - 1);
      repeat (ls[k] == DEPTH ? 1300 : 300)
        cyc(0, $urandom_range(0, 9) < 6, int'($urandom), 0, 0,
            $urandom_range(0, 39) == 0, longint'($urandom));
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
